multicycle_control_unit: RTL and testbench

- Multi-cycle sequencer for the single-issue RV32I datapath.
- Fetches an instruction over a req/ack handshake and latches it into an instruction register. That register drives the datapath's instruction input.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and generates every datapath control: ALU_Controls, reg_wr_en, ALUSrcMuxSel, RAM2RegWSel, branch, PC enable.
- Also drives the data-memory handshake and keeps a retired-instruction counter.

---
 rtl/multicycle_control_unit.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for an RV32I datapath
module multicycle_control_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i_req,
    input  logic        i_ack,
    input  logic [31:0] iData_in,
    output logic [31:0] iData,
    output logic [3:0]  ALU_Controls,
    output logic        ALUSrcMuxSel,
    output logic [1:0]  RAM2RegWSel,
    output logic        reg_wr_en,
    output logic        branch,
    output logic        pc_en,
    output logic        d_req,
    output logic        d_we,
    input  logic        d_ack,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t state, state_nx;
    logic   started;
    logic   mem_first;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc;
    logic       imm_sel;
    logic [3:0] alu_dec;
    logic [1:0] wb_sel;

    assign opcode    = iData[6:0];
    assign funct3    = iData[14:12];
    assign funct7_b5 = iData[30];

    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_ld    = (opcode == 7'b0000011);
    assign is_st    = (opcode == 7'b0100011);
    assign is_br    = (opcode == 7'b1100011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign imm_sel  = is_i | is_ld | is_st;

    // Only shift-right immediates carry an op bit in imm[10]; other I-ALU immediates must not leak it.
    always_comb begin
        alu_dec = 4'b0000;
        if (is_r)
            alu_dec = {funct7_b5, funct3};
        else if (is_i)
            alu_dec = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
        else if (is_br)
            alu_dec = {1'b1, funct3};
    end

    always_comb begin
        wb_sel = 2'd0;
        if (is_ld)
            wb_sel = 2'd1;
        else if (is_lui)
            wb_sel = 2'd2;
        else if (is_auipc)
            wb_sel = 2'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            iData     <= RESET_INSTR;
            instret   <= 32'd0;
            started   <= 1'b0;
            mem_first <= 1'b0;
        end else begin
            state     <= state_nx;
            started   <= 1'b1;
            mem_first <= (state == S_EXECUTE);
            if (i_req && i_ack)
                iData <= iData_in;
            if (pc_en)
                instret <= instret + 32'd1;
        end
    end

    always_comb begin
        state_nx     = state;
        i_req        = 1'b0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        reg_wr_en    = 1'b0;
        pc_en        = 1'b0;
        branch       = 1'b0;
        ALUSrcMuxSel = 1'b0;
        RAM2RegWSel  = 2'd0;
        ALU_Controls = 4'b0000;
        illegal      = 1'b0;
        case (state)
            S_FETCH: begin
                i_req = started;
                if (started && i_ack)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                ALU_Controls = alu_dec;
                ALUSrcMuxSel = imm_sel;
                if (is_r | is_i | is_ld | is_st | is_br)
                    state_nx = S_EXECUTE;
                else if (is_lui | is_auipc)
                    state_nx = S_WB;
                else
                    state_nx = S_TRAP;
            end
            S_EXECUTE: begin
                ALU_Controls = alu_dec;
                ALUSrcMuxSel = imm_sel;
                if (is_br) begin
                    branch   = 1'b1;
                    pc_en    = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_ld | is_st) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                ALU_Controls = alu_dec;
                ALUSrcMuxSel = 1'b1;
                d_req        = 1'b1;
                d_we         = is_st;
                // Store PC update is pulsed on MEM entry so no output depends on d_ack.
                pc_en        = is_st & mem_first;
                if (d_ack)
                    state_nx = is_st ? S_FETCH : S_WB;
            end
            S_WB: begin
                ALU_Controls = alu_dec;
                ALUSrcMuxSel = imm_sel;
                reg_wr_en    = 1'b1;
                pc_en        = 1'b1;
                RAM2RegWSel  = wb_sel;
                state_nx     = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic        i_ack;
    logic [31:0] iData_in;
    logic [31:0] iData;
    logic [3:0]  ALU_Controls;
    logic        ALUSrcMuxSel;
    logic [1:0]  RAM2RegWSel;
    logic        reg_wr_en;
    logic        branch;
    logic        pc_en;
    logic        d_req;
    logic        d_we;
    logic        d_ack;
    logic        illegal;
    logic [31:0] instret;

    multicycle_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_ack        (i_ack),
        .iData_in     (iData_in),
        .iData        (iData),
        .ALU_Controls (ALU_Controls),
        .ALUSrcMuxSel (ALUSrcMuxSel),
        .RAM2RegWSel  (RAM2RegWSel),
        .reg_wr_en    (reg_wr_en),
        .branch       (branch),
        .pc_en        (pc_en),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_ack        (d_ack),
        .illegal      (illegal),
        .instret      (instret)
    );

    logic [6:0] strobes;
    assign strobes = {i_req, d_req, d_we, reg_wr_en, pc_en, branch, ALUSrcMuxSel};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    int         n_cyc, n_rw, rw_cyc, n_pc, pc_cyc, n_br, br_cyc, n_dreq, n_dwe, dreq_pc_cyc;
    logic       ireq_c1, rw_src, alu_var, timed_out;
    logic [1:0] rw_sel;
    logic [3:0] rw_alu, br_alu;
    int         trap_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge in a FETCH cycle; returns at the negedge of the next fetch.
    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw);
        int   ic, dc;
        logic fetched, ack_now, alu_set;
        logic [3:0] alu_ref;
        ic = 0; dc = 0; fetched = 0; alu_set = 0; alu_ref = 0;
        n_cyc = 0; n_rw = 0; rw_cyc = 0; n_pc = 0; pc_cyc = 0; n_br = 0; br_cyc = 0;
        n_dreq = 0; n_dwe = 0; dreq_pc_cyc = 0; ireq_c1 = 0; rw_src = 0; alu_var = 0;
        rw_sel = 0; rw_alu = 0; br_alu = 0; timed_out = 1;
        while (n_cyc < 40) begin
            if (fetched && i_req) begin
                timed_out = 0;
                break;
            end
            n_cyc++;
            ack_now = i_req && (ic == iw);
            if (i_req) ic++;
            i_ack = ack_now;
            iData_in = instr;
            d_ack = d_req && (dc == dw);
            if (d_req) dc++;
            #1;
            if (n_cyc == 1) ireq_c1 = i_req;
            if (fetched) begin
                if (!alu_set) begin
                    alu_ref = ALU_Controls;
                    alu_set = 1;
                end else if (ALU_Controls !== alu_ref) begin
                    alu_var = 1;
                end
            end
            if (reg_wr_en) begin
                n_rw++; rw_cyc = n_cyc; rw_sel = RAM2RegWSel; rw_alu = ALU_Controls; rw_src = ALUSrcMuxSel;
            end
            if (pc_en) begin
                n_pc++; pc_cyc = n_cyc;
            end
            if (branch) begin
                n_br++; br_cyc = n_cyc; br_alu = ALU_Controls;
            end
            if (d_req) begin
                n_dreq++;
                if (d_we) n_dwe++;
                if (pc_en) dreq_pc_cyc = n_cyc;
            end
            if (ack_now) fetched = 1;
            @(negedge clk);
        end
        i_ack = 0;
        d_ack = 0;
    endtask

    initial begin
        rst = 1; i_ack = 0; d_ack = 0; iData_in = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_iData", iData, 32'h0000_0013);
        check("reset_instret", instret, 32'd0);
        check("reset_illegal", illegal, 1'b0);
        check("reset_strobes", strobes, 7'd0);
        check("reset_wsel", RAM2RegWSel, 2'd0);
        check("reset_alu", ALU_Controls, 4'd0);
        @(negedge clk);
        rst = 0;
        #1;
        check("ireq_before_first_edge", i_req, 1'b0);
        @(negedge clk);

        run_instr(32'h0050_0093, 0, 0);
        check("addi_ireq_cycle1", ireq_c1, 1'b1);
        check("addi_timeout", timed_out, 1'b0);
        check("addi_cycles", n_cyc, 4);
        check("addi_wb_cycle", rw_cyc, 4);
        check("addi_rw_count", n_rw, 1);
        check("addi_wsel", rw_sel, 2'd0);
        check("addi_alu", rw_alu, 4'b0000);
        check("addi_srcsel", rw_src, 1'b1);
        check("addi_pc_count", n_pc, 1);
        check("addi_instret", instret, 32'd1);

        run_instr(32'h0000_A103, 0, 3);
        check("lw_cycles", n_cyc, 8);
        check("lw_dreq_cycles", n_dreq, 4);
        check("lw_dwe_cycles", n_dwe, 0);
        check("lw_rw_count", n_rw, 1);
        check("lw_wsel", rw_sel, 2'd1);
        check("lw_pc_count", n_pc, 1);
        check("lw_instret", instret, 32'd2);

        run_instr(32'h0020_A223, 0, 0);
        check("sw_cycles", n_cyc, 4);
        check("sw_dreq_cycles", n_dreq, 1);
        check("sw_dwe_cycles", n_dwe, 1);
        check("sw_pc_with_dreq", dreq_pc_cyc, 4);
        check("sw_rw_count", n_rw, 0);
        check("sw_pc_count", n_pc, 1);
        check("sw_instret", instret, 32'd3);

        run_instr(32'h0010_8463, 0, 0);
        check("beq_cycles", n_cyc, 3);
        check("beq_branch_count", n_br, 1);
        check("beq_branch_cycle", br_cyc, 3);
        check("beq_pc_cycle", pc_cyc, 3);
        check("beq_alu", br_alu, 4'b1000);
        check("beq_rw_count", n_rw, 0);
        check("beq_alu_stable", alu_var, 1'b0);

        run_instr(32'h4020_81B3, 0, 0);
        check("sub_cycles", n_cyc, 4);
        check("sub_alu", rw_alu, 4'b1000);
        check("sub_srcsel", rw_src, 1'b0);
        check("sub_alu_stable", alu_var, 1'b0);

        run_instr(32'h4020_D093, 0, 0);
        check("srai_alu", rw_alu, 4'b1101);
        check("srai_srcsel", rw_src, 1'b1);

        run_instr(32'h4000_8093, 0, 0);
        check("addi_imm_bit30_alu", rw_alu, 4'b0000);

        run_instr(32'h1234_51B7, 0, 0);
        check("lui_cycles", n_cyc, 3);
        check("lui_wb_cycle", rw_cyc, 3);
        check("lui_wsel", rw_sel, 2'd2);

        run_instr(32'h0000_1217, 0, 0);
        check("auipc_cycles", n_cyc, 3);
        check("auipc_wsel", rw_sel, 2'd3);

        run_instr(32'h0050_0093, 2, 0);
        check("addi_fetchwait_cycles", n_cyc, 6);
        check("addi_fetchwait_rw", n_rw, 1);

        run_instr(32'h0020_A223, 0, 2);
        check("sw_wait_cycles", n_cyc, 6);
        check("sw_wait_dreq_cycles", n_dreq, 3);
        check("sw_wait_pc_count", n_pc, 1);
        check("sw_wait_rw_count", n_rw, 0);
        check("instret_after_11", instret, 32'd11);

        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        @(negedge clk);
        run_instr(32'h0050_0093, 0, 0);
        check("instret_wrap", instret, 32'd0);

        iData_in = 32'h0000_A103;
        i_ack = 1;
        @(negedge clk);
        i_ack = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mem_dreq_before_rst", d_req, 1'b1);
        rst = 1;
        #1;
        check("mem_rst_dreq_drop", d_req, 1'b0);
        check("mem_rst_iData", iData, 32'h0000_0013);
        check("mem_rst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        iData_in = 32'h0000_007F;
        i_ack = 1;
        @(negedge clk);
        i_ack = 0;
        #1;
        check("trap_decode_illegal", illegal, 1'b0);
        @(negedge clk);
        #1;
        check("trap_illegal_set", illegal, 1'b1);
        trap_bad = 0;
        for (int k = 0; k < 6; k++) begin
            i_ack = k[0];
            d_ack = ~k[0];
            @(negedge clk);
            #1;
            if (!illegal || strobes !== 7'd0) trap_bad++;
        end
        i_ack = 0;
        d_ack = 0;
        check("trap_sticky_quiet", trap_bad, 0);
        check("trap_instret", instret, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
